// File: rtl/efuse_pkg.sv
// efuse_pkg: shared constants, FSM state enum and error-flag indices for the eFuse macro emulator
package efuse_pkg;
    localparam int FUSE_BITS  = 256;
    localparam int FUSE_BYTES = 32;
    localparam int ADDR_W     = 8;
    localparam int BYTE_IDX_W = $clog2(FUSE_BYTES);
    localparam int WIDTH_W    = 10;
    // positions of the sticky error flags inside the error vector
    localparam int ERR_TIMING   = 0;
    localparam int ERR_CONFLICT = 1;
    localparam int ERR_ADDR     = 2;
    localparam int ERR_N        = 3;
    typedef enum logic [2:0] {IDLE, RD_ARM, RD_STRB, PG_ARM, PG_STRB} efuse_state_e;
endpackage

// File: rtl/efuse_macro_emu_if.sv
// efuse_macro_emu_if: controller <-> fuse macro strobe bus
//   master (controller): drives pgmen/rden/aen/addr, receives rdata
//   slave  (macro):      receives pgmen/rden/aen/addr, drives rdata
interface efuse_macro_emu_if;
    import efuse_pkg::*;
    logic              efuse_pgmen_i;
    logic              efuse_rden_i;
    logic              efuse_aen_i;
    logic [ADDR_W-1:0] efuse_addr_i;
    logic [7:0]        efuse_rdata_o;
    modport master (output efuse_pgmen_i, efuse_rden_i, efuse_aen_i, efuse_addr_i, input efuse_rdata_o);
    modport slave  (input efuse_pgmen_i, efuse_rden_i, efuse_aen_i, efuse_addr_i, output efuse_rdata_o);
endinterface

// File: rtl/efuse_strobe_meter.sv
// efuse_strobe_meter: aen edge detection plus saturating strobe-width counter
//   clk, rst  : clock, async active-high reset
//   aen       : access strobe (synchronous to clk)
//   en        : counting enable (FSM is in a strobe state)
//   aen_rise  : aen high now, low last cycle
//   aen_fall  : aen low now, high last cycle
//   width     : number of cycles aen was sampled high in the current strobe
module efuse_strobe_meter
    import efuse_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               aen,
    input  logic               en,
    output logic               aen_rise,
    output logic               aen_fall,
    output logic [WIDTH_W-1:0] width
);
    logic aen_d;
    assign aen_rise = aen & ~aen_d;
    assign aen_fall = ~aen & aen_d;
    // the rising-edge cycle restarts the count at 1 so width equals the
    // number of high cycles once the falling edge is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aen_d <= 1'b0;
            width <= '0;
        end else begin
            aen_d <= aen;
            width <= aen_rise ? WIDTH_W'(1) :
                     (en && aen && width != '1) ? width + WIDTH_W'(1) : width;
        end
    end
endmodule

// File: rtl/efuse_macro_emu.sv
// efuse_macro_emu: behavioural emulation of a 256-bit one-time-programmable fuse macro
//   clk, rst     : clock, async active-high reset
//   bus          : strobe bus (pgmen, rden, aen, addr in; registered rdata out)
//   err_clr      : one-cycle clear of the sticky error flags (a same-cycle set wins)
//   err_timing   : short strobe or enable dropped mid-strobe
//   err_conflict : read and program enables active together
//   err_addr     : address moved during a strobe or read byte index out of range
//   fuse_bits    : current array contents
//   pgm_count    : bits newly blown since reset, saturating at 256
module efuse_macro_emu
    import efuse_pkg::*;
#(
    parameter logic [FUSE_BITS-1:0] INIT     = '0,
    parameter logic [5:0]           TRD_MIN  = 6'd2,
    parameter logic [9:0]           TPGM_MIN = 10'd16
) (
    input  logic                 clk,
    input  logic                 rst,
    efuse_macro_emu_if.slave     bus,
    input  logic                 err_clr,
    output logic                 err_timing,
    output logic                 err_conflict,
    output logic                 err_addr,
    output logic [FUSE_BITS-1:0] fuse_bits,
    output logic [8:0]           pgm_count
);
    efuse_state_e       state;
    logic [ADDR_W-1:0]  addr_q;
    logic [FUSE_BITS-1:0] fuse;
    logic [ERR_N-1:0]   err_q;
    logic [7:0]         rdata_q;
    logic               aen_rise, aen_fall;
    logic [WIDTH_W-1:0] width;
    logic               rd, pg, rd_short, pg_short, bad_byte, addr_moved;
    logic [7:0]         byte_sel;

    efuse_strobe_meter u_meter (
        .clk      (clk),
        .rst      (rst),
        .aen      (bus.efuse_aen_i),
        .en       (state == RD_STRB || state == PG_STRB),
        .aen_rise (aen_rise),
        .aen_fall (aen_fall),
        .width    (width)
    );

    assign rd         = bus.efuse_rden_i;
    assign pg         = bus.efuse_pgmen_i;
    assign rd_short   = width < WIDTH_W'(TRD_MIN);
    assign pg_short   = width < TPGM_MIN;
    assign bad_byte   = |addr_q[ADDR_W-1:BYTE_IDX_W];
    assign addr_moved = bus.efuse_addr_i != addr_q;
    assign byte_sel   = fuse[{addr_q[BYTE_IDX_W-1:0], 3'b000} +: 8];

    assign bus.efuse_rdata_o = rdata_q;
    assign err_timing        = err_q[ERR_TIMING];
    assign err_conflict      = err_q[ERR_CONFLICT];
    assign err_addr          = err_q[ERR_ADDR];
    assign fuse_bits         = fuse;

    // error sets are written after the clear so the later assignment wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            fuse      <= INIT;
            rdata_q   <= 8'h00;
            err_q     <= '0;
            pgm_count <= '0;
        end else begin
            if (err_clr)
                err_q <= '0;
            case (state)
                IDLE: begin
                    if (rd && pg)
                        err_q[ERR_CONFLICT] <= 1'b1;
                    else if (rd)
                        state <= RD_ARM;
                    else if (pg)
                        state <= PG_ARM;
                end
                RD_ARM: begin
                    if (pg) begin
                        err_q[ERR_CONFLICT] <= 1'b1;
                        state <= IDLE;
                    end else if (!rd)
                        state <= IDLE;
                    else if (aen_rise) begin
                        state  <= RD_STRB;
                        addr_q <= bus.efuse_addr_i;
                    end
                end
                RD_STRB: begin
                    if (pg) begin
                        err_q[ERR_CONFLICT] <= 1'b1;
                        state <= IDLE;
                    end else if (!rd) begin
                        err_q[ERR_TIMING] <= 1'b1;
                        state <= IDLE;
                    end else if (addr_moved) begin
                        err_q[ERR_ADDR] <= 1'b1;
                        state <= RD_ARM;
                    end else if (aen_fall) begin
                        state   <= RD_ARM;
                        rdata_q <= (rd_short || bad_byte) ? 8'h00 : byte_sel;
                        if (rd_short)
                            err_q[ERR_TIMING] <= 1'b1;
                        if (bad_byte)
                            err_q[ERR_ADDR] <= 1'b1;
                    end
                end
                PG_ARM: begin
                    if (rd) begin
                        err_q[ERR_CONFLICT] <= 1'b1;
                        state <= IDLE;
                    end else if (!pg)
                        state <= IDLE;
                    else if (aen_rise) begin
                        state  <= PG_STRB;
                        addr_q <= bus.efuse_addr_i;
                    end
                end
                PG_STRB: begin
                    if (rd) begin
                        err_q[ERR_CONFLICT] <= 1'b1;
                        state <= IDLE;
                    end else if (!pg) begin
                        err_q[ERR_TIMING] <= 1'b1;
                        state <= IDLE;
                    end else if (addr_moved) begin
                        err_q[ERR_ADDR] <= 1'b1;
                        state <= PG_ARM;
                    end else if (aen_fall) begin
                        state <= PG_ARM;
                        if (pg_short)
                            err_q[ERR_TIMING] <= 1'b1;
                        else begin
                            fuse[addr_q] <= 1'b1;
                            if (!fuse[addr_q] && pgm_count != 9'd256)
                                pgm_count <= pgm_count + 9'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_efuse_macro_emu.sv
// tb_efuse_macro_emu: directed self-checking bench with a read-data scoreboard and fuse model
module tb_efuse_macro_emu;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         err_clr = 1'b0;
    logic         err_timing, err_conflict, err_addr;
    logic [255:0] fuse_bits;
    logic [8:0]   pgm_count;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] model = '0;
    int           model_cnt = 0;
    logic [7:0]   exp_q[$];

    efuse_macro_emu_if bus ();

    efuse_macro_emu dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .err_clr      (err_clr),
        .err_timing   (err_timing),
        .err_conflict (err_conflict),
        .err_addr     (err_addr),
        .fuse_bits    (fuse_bits),
        .pgm_count    (pgm_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // full handshake: enable, aen high for n cycles, fall, disable
    task automatic access(input bit pg, input logic [7:0] a, input int n);
        logic [7:0] e;
        if (pg) bus.efuse_pgmen_i = 1'b1;
        else    bus.efuse_rden_i  = 1'b1;
        tick(1);
        bus.efuse_addr_i = a;
        bus.efuse_aen_i  = 1'b1;
        tick(n);
        bus.efuse_aen_i = 1'b0;
        if (!pg) begin
            e = (n < 2 || a[7:5] != 3'd0) ? 8'h00 : model[{a[4:0], 3'b000} +: 8];
            exp_q.push_back(e);
        end else if (n >= 16) begin
            if (!model[a]) model_cnt++;
            model[a] = 1'b1;
        end
        tick(1);
        bus.efuse_pgmen_i = 1'b0;
        bus.efuse_rden_i  = 1'b0;
        tick(1);
        if (!pg) check("rdata", bus.efuse_rdata_o, exp_q.pop_front());
    endtask

    initial begin
        bus.efuse_pgmen_i = 1'b0;
        bus.efuse_rden_i  = 1'b0;
        bus.efuse_aen_i   = 1'b0;
        bus.efuse_addr_i  = 8'h00;
        #1 rst = 1'b1;
        tick(2);
        check("rst_rdata", bus.efuse_rdata_o, 8'h00);
        check("rst_errs", {err_timing, err_conflict, err_addr}, 3'b000);
        check("rst_fuse", fuse_bits, 256'h0);
        check("rst_count", pgm_count, 9'd0);
        rst = 1'b0;
        tick(1);

        access(0, 8'h03, 3);
        check("rd_noerr", {err_timing, err_conflict, err_addr}, 3'b000);

        access(1, 8'd25, 16);
        check("pg25_fuse", fuse_bits, model);
        check("pg25_count", pgm_count, 9'(model_cnt));
        access(0, 8'h03, 3);
        check("rd3_after_pg", bus.efuse_rdata_o, 8'h02);
        check("pg25_count1", pgm_count, 9'd1);
        access(1, 8'd25, 16);
        check("repg25_count", pgm_count, 9'd1);

        access(1, 8'd7, 15);
        check("short_pg_err", err_timing, 1'b1);
        check("short_pg_bit", fuse_bits[7], 1'b0);
        clear_errs();
        check("clr_timing", err_timing, 1'b0);

        bus.efuse_rden_i  = 1'b1;
        bus.efuse_pgmen_i = 1'b1;
        tick(1);
        check("conflict", err_conflict, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("set_wins", err_conflict, 1'b1);
        check("conflict_fuse", fuse_bits, model);
        bus.efuse_rden_i  = 1'b0;
        bus.efuse_pgmen_i = 1'b0;
        tick(1);
        clear_errs();
        check("clr_conflict", err_conflict, 1'b0);

        access(0, 8'h20, 3);
        check("bad_byte_err", err_addr, 1'b1);
        clear_errs();

        access(0, 8'h03, 3);
        access(0, 8'h03, 1);
        check("short_rd_err", err_timing, 1'b1);
        clear_errs();

        access(1, 8'd24, 20);
        access(0, 8'h03, 2);
        check("two_bits", bus.efuse_rdata_o, 8'h03);
        check("count2", pgm_count, 9'(model_cnt));

        bus.efuse_rden_i = 1'b1;
        tick(1);
        bus.efuse_pgmen_i = 1'b1;
        tick(1);
        check("pg_in_rd", err_conflict, 1'b1);
        bus.efuse_rden_i  = 1'b0;
        bus.efuse_pgmen_i = 1'b0;
        tick(1);
        clear_errs();

        bus.efuse_pgmen_i = 1'b1;
        tick(1);
        bus.efuse_addr_i = 8'd60;
        bus.efuse_aen_i  = 1'b1;
        tick(5);
        bus.efuse_pgmen_i = 1'b0;
        tick(1);
        bus.efuse_aen_i = 1'b0;
        tick(2);
        check("drop_err", err_timing, 1'b1);
        check("drop_fuse", fuse_bits, model);
        clear_errs();

        bus.efuse_pgmen_i = 1'b1;
        tick(1);
        bus.efuse_addr_i = 8'd40;
        bus.efuse_aen_i  = 1'b1;
        tick(3);
        bus.efuse_addr_i = 8'd41;
        tick(14);
        bus.efuse_aen_i = 1'b0;
        tick(1);
        bus.efuse_pgmen_i = 1'b0;
        tick(1);
        check("move_err", err_addr, 1'b1);
        check("move_fuse", fuse_bits, model);
        check("move_count", pgm_count, 9'(model_cnt));
        clear_errs();

        bus.efuse_pgmen_i = 1'b1;
        tick(1);
        bus.efuse_addr_i = 8'd50;
        bus.efuse_aen_i  = 1'b1;
        tick(5);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdata", bus.efuse_rdata_o, 8'h00);
        check("mid_rst_fuse", fuse_bits, 256'h0);
        check("mid_rst_count", pgm_count, 9'd0);
        check("mid_rst_errs", {err_timing, err_conflict, err_addr}, 3'b000);
        bus.efuse_aen_i   = 1'b0;
        bus.efuse_pgmen_i = 1'b0;
        bus.efuse_addr_i  = 8'h00;
        tick(1);
        rst = 1'b0;
        model     = '0;
        model_cnt = 0;
        tick(2);
        check("post_rst_fuse", fuse_bits, model);

        access(1, 8'd50, 16);
        access(0, 8'h06, 3);
        check("byte6", bus.efuse_rdata_o, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/efuse_macro_emu.md
EFUSE_MACRO_EMU -- requirements
Module: efuse_macro_emu

Interface
REQ-001 SHALL have parameter INIT, 256 bits, default all zeros: fuse array content after reset.
REQ-002 SHALL have parameter TRD_MIN, 6 bits, default 2: minimum aen-high cycles for a valid read strobe.
REQ-003 SHALL have parameter TPGM_MIN, 10 bits, default 16: minimum aen-high cycles for a valid program strobe.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  sole clock (6.5M domain, same as controller); rst  in  1  async active-high reset.
REQ-005 SHALL have port efuse_pgmen_i  in  1  program enable from controller.
REQ-006 SHALL have port efuse_rden_i  in  1  read enable from controller.
REQ-007 SHALL have port efuse_aen_i  in  1  access strobe from controller.
REQ-008 SHALL have port efuse_addr_i  in  8  program: bit index 0..255; read: byte index in [4:0], with [7:5] required zero.
REQ-009 SHALL have port efuse_rdata_o  out  8  read byte, registered.
REQ-010 SHALL have port err_clr  in  1  single-cycle clear of all sticky error flags.
REQ-011 SHALL have ports err_timing, err_conflict, err_addr  out  1 each  sticky error flags.
REQ-012 SHALL have port fuse_bits  out  256  current array, debug view.
REQ-013 SHALL have port pgm_count  out  9  count of bits newly blown since reset, saturating at 256.

Function
REQ-014 SHALL treat all inputs as synchronous to clk and register efuse_aen_i once internally for edge detection.
REQ-015 SHALL run FSM with states IDLE, RD_ARM, RD_STRB, PG_ARM, PG_STRB.
REQ-016 From IDLE: rden=1 and pgmen=0 -> RD_ARM; pgmen=1 and rden=0 -> PG_ARM; both=1 -> set err_conflict and stay in IDLE.
REQ-017 RD_ARM: aen rising -> RD_STRB, latch addr, clear width counter; rden falling -> IDLE.
REQ-018 PG_ARM: aen rising -> PG_STRB, latch addr, clear width counter; pgmen falling -> IDLE.
REQ-019 In *_STRB, width counter SHALL increment each cycle aen=1 and saturate at 1023.
REQ-020 A change of efuse_addr_i while in *_STRB SHALL set err_addr and suppress that access.
REQ-021 On aen falling in RD_STRB with width>=TRD_MIN and latched addr[7:5]=0: efuse_rdata_o <= fuse[8*addr+7 : 8*addr], valid the cycle after the falling edge is sampled; next state RD_ARM.
REQ-022 In RD_STRB, width<TRD_MIN SHALL set err_timing and drive efuse_rdata_o to 8'h00; nonzero addr[7:5] SHALL set err_addr and drive 8'h00.
REQ-023 On aen falling in PG_STRB with width>=TPGM_MIN: fuse[addr] <= 1 (OR only, never cleared); pgm_count SHALL increment only if the bit was 0; next state PG_ARM.
REQ-024 In PG_STRB, width<TPGM_MIN SHALL set err_timing and leave the array unchanged.
REQ-025 rden or pgmen dropping while aen=1 SHALL set err_timing, abort without update, and return to IDLE.
REQ-026 Mode enable rising in a non-IDLE state of the opposite mode SHALL set err_conflict and abort to IDLE.
REQ-027 Same-cycle err_clr and new error: set wins.

Reset
REQ-028 rst SHALL asynchronously set: FSM IDLE, fuse array = INIT, efuse_rdata_o 8'h00, all err flags 0, pgm_count 0, width counter 0, aen delay register 0.
REQ-029 Reset during an active strobe SHALL discard the pending access.

Structure
REQ-030 FSM state enum, address/array widths (256 bits, 32 bytes) and error-code constants SHALL reside in shared package efuse_pkg.
REQ-031 A sub-module efuse_strobe_meter (aen edge detect plus saturating width counter) SHALL be instantiated once; the array and FSM stay in top.

Verification
REQ-032 INIT=0; rden=1, addr=8'h03, aen held 3 cycles -> rdata=8'h00, no errors.
REQ-033 pgmen=1, addr=8'd25, aen 16 cycles; then read addr=8'h03 -> rdata=8'h02, pgm_count=1; repeat program of bit 25 -> pgm_count stays 1.
REQ-034 pgmen=1, addr=8'd7, aen 15 cycles -> err_timing=1, fuse_bits[7]=0; err_clr pulse -> err_timing=0.
REQ-035 rden=1 and pgmen=1 together -> err_conflict=1, no array change; read addr=8'h20 -> err_addr=1, rdata=8'h00.
REQ-036 Address change mid-strobe during program -> err_addr=1, array unchanged; rst asserted mid-strobe -> all outputs at reset values, array=INIT.
